// File: rtl/mux_n_stage.sv
// NUM_IN-way WIDTH-bit operand select with a registered valid/ready output stage and 2-entry skid.
// Optional sticky out-of-range select flag: define MUX_N_STAGE_SEL_CHECK_EN.
module mux_n_stage #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic                    sel_err
);

    logic [WIDTH-1:0] mux_word;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             accept;
    logic             main_free;

    // Out-of-range selects fall through to the all-zero default.
    always_comb begin
        mux_word = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                mux_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    assign main_free = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_data  <= mux_word;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            // Main is stalled: park the accepted word so in_ready can stay registered.
            skid_data  <= mux_word;
            skid_valid <= 1'b1;
        end
    end

`ifdef MUX_N_STAGE_SEL_CHECK_EN
    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (accept && (32'(sel) >= NUM_IN)) begin
            sel_err <= 1'b1;
        end
    end
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_stage.sv
// Scoreboard bench for mux_n_stage: a 4-input instance for flow control and a 3-input one for select range.
module tb_mux_n_stage;

    localparam int unsigned WIDTH = 64;
`ifdef MUX_N_STAGE_SEL_CHECK_EN
    localparam logic SEL_CHK = 1'b1;
`else
    localparam logic SEL_CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [4*WIDTH-1:0] in_data = '0;
    logic [1:0]       sel = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             flush = 1'b0;
    logic             sel_err;

    logic [3*WIDTH-1:0] in3_data = '0;
    logic [1:0]       sel3 = '0;
    logic             in3_valid = 1'b0;
    logic             in3_ready;
    logic [WIDTH-1:0] out3_data;
    logic             out3_valid;
    logic             out3_ready = 1'b1;
    logic             flush3 = 1'b0;
    logic             sel_err3;

    int unsigned      pass_cnt = 0;
    int unsigned      total_cnt = 0;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] cur_exp = '0;

    always #5 clk = ~clk;

    mux_n_stage #(.WIDTH(WIDTH), .NUM_IN(4), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .flush(flush), .sel_err(sel_err)
    );

    mux_n_stage #(.WIDTH(WIDTH), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in3_data), .sel(sel3), .in_valid(in3_valid),
        .in_ready(in3_ready), .out_data(out3_data), .out_valid(out3_valid),
        .out_ready(out3_ready), .flush(flush3), .sel_err(sel_err3)
    );

    // Scoreboard: pop on each output handshake, push on each non-flushed accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected: out_data=%h delivered, none expected", out_data);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = sb.pop_front();
                    if (out_data !== e) $display("FAIL sb_data: got %h expected %h", out_data, e);
                    else pass_cnt++;
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    // Place word in slot s (other slots random) and assert in_valid; no waiting.
    task automatic drive_word(input logic [WIDTH-1:0] word, input logic [1:0] s, input logic rdy);
        logic [WIDTH-1:0] w [4];
        for (int k = 0; k < 4; k++) w[k] = {$urandom, $urandom};
        w[s] = word;
        in_data   = {w[3], w[2], w[1], w[0]};
        sel       = s;
        cur_exp   = word;
        in_valid  = 1'b1;
        out_ready = rdy;
    endtask

    // Drive after the next edge and return on the negedge before the accepting edge.
    task automatic send(input logic [WIDTH-1:0] word, input logic [1:0] s, input logic rdy);
        bit ok;
        @(posedge clk); #1;
        drive_word(word, s, rdy);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            total_cnt++;
            $display("FAIL send_timeout: word %h never accepted", word);
        end
    endtask

    task automatic idle_input();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        total_cnt++;
        if (!done) $display("FAIL %s_drain: %0d words outstanding, out_valid=%b", name, sb.size(), out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #12 rst_n = 1'b1;
        @(negedge clk);
        total_cnt += 5;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        if (out_data !== '0) $display("FAIL reset_out_data: got %h expected 0", out_data); else pass_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        if (sel_err !== 1'b0) $display("FAIL reset_sel_err: got %b expected 0", sel_err); else pass_cnt++;
        if (sel_err3 !== 1'b0) $display("FAIL reset_sel_err3: got %b expected 0", sel_err3); else pass_cnt++;
    endtask

    task automatic test_streaming();
        logic [WIDTH-1:0] pat [4];
        pat[0] = 64'h1111_1111_1111_1111;
        pat[1] = 64'h2222_2222_2222_2222;
        pat[2] = 64'h3333_3333_3333_3333;
        pat[3] = 64'h4444_4444_4444_4444;
        for (int i = 0; i < 4; i++) begin
            send(pat[i], 2'(i), 1'b1);
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready);
            else pass_cnt++;
            if (i > 0) begin
                total_cnt++;
                if (out_valid !== 1'b1) $display("FAIL stream_out_valid[%0d]: got %b expected 1", i, out_valid);
                else pass_cnt++;
            end
        end
        idle_input();
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== pat[3])
            $display("FAIL stream_last: got v=%b %h expected v=1 %h", out_valid, out_data, pat[3]);
        else pass_cnt++;
        wait_drain("stream");
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] a, b, c;
        bit ok;
        a = 64'hAAAA_0000_0000_000A;
        b = 64'hBBBB_0000_0000_000B;
        c = 64'hCCCC_0000_0000_000C;
        send(a, 2'd0, 1'b1);
        send(b, 2'd1, 1'b0);
        @(posedge clk); #1;
        drive_word(c, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt += 2;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready);
            else pass_cnt++;
            if (out_valid !== 1'b1 || out_data !== a)
                $display("FAIL bp_hold[%0d]: got v=%b %h expected v=1 %h", i, out_valid, out_data, a);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        total_cnt++;
        if (!ok) $display("FAIL bp_recover: in_ready stayed %b expected 1", in_ready); else pass_cnt++;
        idle_input();
        wait_drain("bp");
    endtask

    task automatic test_flush();
        send(64'hDEAD_0000_0000_0001, 2'd3, 1'b0);
        send(64'hDEAD_0000_0000_0002, 2'd2, 1'b0);
        @(posedge clk); #1;
        drive_word(64'hDEAD_0000_0000_0003, 2'd1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL flush_pre_full: in_ready=%b expected 0", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total_cnt += 2;
        if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain("flush_empty");
        send(64'hE0E0_E0E0_1234_5678, 2'd0, 1'b1);
        idle_input();
        wait_drain("flush_after");
    endtask

    task automatic test_out_of_range();
        logic [WIDTH-1:0] w2;
        w2 = 64'h0F0F_F0F0_5A5A_A5A5;
        @(posedge clk); #1;
        in3_data  = {w2, 64'h1234_0000_0000_0001, 64'h1234_0000_0000_0000};
        sel3      = 2'd2;
        in3_valid = 1'b1;
        @(posedge clk); #1;
        sel3 = 2'd3;
        @(negedge clk);
        total_cnt += 2;
        if (out3_valid !== 1'b1 || out3_data !== w2)
            $display("FAIL oor_good: got v=%b %h expected v=1 %h", out3_valid, out3_data, w2);
        else pass_cnt++;
        if (sel_err3 !== 1'b0) $display("FAIL oor_err_early: got %b expected 0", sel_err3); else pass_cnt++;
        @(posedge clk); #1;
        in3_valid = 1'b0;
        @(negedge clk);
        total_cnt += 2;
        if (out3_valid !== 1'b1 || out3_data !== '0)
            $display("FAIL oor_zero: got v=%b %h expected v=1 0", out3_valid, out3_data);
        else pass_cnt++;
        if (sel_err3 !== SEL_CHK) $display("FAIL oor_err: got %b expected %b", sel_err3, SEL_CHK); else pass_cnt++;
        @(posedge clk); #1;
        flush3 = 1'b1;
        @(posedge clk); #1;
        flush3 = 1'b0;
        @(negedge clk);
        total_cnt += 2;
        if (sel_err3 !== SEL_CHK) $display("FAIL oor_err_sticky: got %b expected %b", sel_err3, SEL_CHK); else pass_cnt++;
        if (out3_valid !== 1'b0) $display("FAIL oor_flush: out3_valid=%b expected 0", out3_valid); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        send(64'h7777_0000_0000_0001, 2'd1, 1'b1);
        send(64'h7777_0000_0000_0002, 2'd2, 1'b1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        total_cnt += 4;
        if (out_valid !== 1'b0) $display("FAIL arst_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        if (out_data !== '0) $display("FAIL arst_out_data: got %h expected 0", out_data); else pass_cnt++;
        if (in_ready !== 1'b1) $display("FAIL arst_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        if (sel_err3 !== 1'b0) $display("FAIL arst_sel_err3: got %b expected 0", sel_err3); else pass_cnt++;
        @(negedge clk); #2;
        rst_n = 1'b1;
        send(64'h8888_0000_0000_0008, 2'd3, 1'b1);
        idle_input();
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 64'h8888_0000_0000_0008)
            $display("FAIL arst_first: got v=%b %h expected v=1 8888000000000008", out_valid, out_data);
        else pass_cnt++;
        wait_drain("arst");
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_out_of_range();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mux_n_stage.md
# mux_n_stage

Parametrised N-way operand multiplexer with a registered, flow-controlled output stage for the pipelined datapath. It generalises the fixed 64-bit 2:1 select into a WIDTH-bit, NUM_IN-way select. It sits between a pipeline stage's operand sources and the next stage's input register. A 2-entry skid buffer gives full throughput under valid/ready backpressure, and a flush input squashes in-flight words on branch or exception.

## Interface
- WIDTH, 64, data width of each input and of the output
- NUM_IN, 4, number of selectable inputs (2..16)
- SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_IN
- clk  input  1  clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- sel  input  SEL_W  input index, sampled with in_data
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word this cycle
- out_data  output  WIDTH  selected, registered word
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- flush  input  1  synchronous squash of all held words
- sel_err  output  1  sticky out-of-range select flag (only with MUX_N_STAGE_SEL_CHECK_EN)

## Operation
- Accept = in_valid & in_ready. Muxed word m = in_data slice[sel] if sel < NUM_IN, else all zeros.
- Storage: main register (drives out_data/out_valid) plus one skid register (skid_data, skid_valid).
- in_ready = ~skid_valid. It depends only on registered state and has no combinational path from out_ready.
- Per rising edge, with flush = 0:
  - If out_valid = 0 or out_ready = 1, the main register loads one of:
    - skid contents, if skid_valid (then skid_valid <= 0);
    - m, if accept (out_valid <= 1);
    - nothing otherwise (out_valid <= 0).
  - If out_valid = 1, out_ready = 0 and accept, the skid register loads m (skid_valid <= 1). The main register holds.
  - Accept and skid_valid never coincide, because in_ready = 0 whenever skid_valid = 1.
- Flush = 1 at an edge:
  - out_valid <= 0 and skid_valid <= 0.
  - Any word accepted in the same cycle is discarded.
  - Flush overrides every other update.
  - Data registers may keep stale values.
- Ordering is strict FIFO. No word is duplicated or dropped except by flush.
- Reset mid-operation clears all valid state immediately, without waiting for a clock edge.

## Timing
- Reset values: out_valid = 0, out_data = 0, skid_valid = 0, in_ready = 1, sel_err = 0.
- Latency: an accepted word appears on out_data/out_valid in the cycle after acceptance.
- Throughput: one word per cycle while out_ready = 1.
- Backpressure: after out_ready drops, at most one more word is accepted (into skid), and in_ready goes low the following cycle.
- Recovery: the first out_ready = 1 cycle drains the main register; the skid word moves to main; in_ready returns high on the next cycle.
- Flush: out_valid = 0 and in_ready = 1 in the cycle after a flush edge.
- Stability: out_data and out_valid hold stable while out_valid = 1 and out_ready = 0.

## Configuration
- Macro: MUX_N_STAGE_SEL_CHECK_EN.
- Defined:
  - sel_err is set at any accept with sel >= NUM_IN.
  - It stays set until rst_n is asserted; flush does not clear it.
  - The offending word still passes through as zeros.
- Undefined:
  - sel_err is tied to 0.
  - The check logic is not built.
  - The out-of-range select still yields zeros.

## Test plan
- Streaming, WIDTH = 64, NUM_IN = 4, out_ready held 1: inputs 0x11.., 0x22.., 0x33.., 0x44.. with sel = 0,1,2,3 on successive cycles -> out_data shows 0x11..,0x22..,0x33..,0x44.. one cycle later each, out_valid continuously 1, in_ready continuously 1.
- Backpressure: send A, B, C back-to-back; out_ready = 0 from the cycle A appears -> B goes to skid, in_ready = 0, C held upstream. Raising out_ready -> A, B, C delivered in order, none lost or duplicated.
- Flush: with main and skid both full, pulse flush with in_valid = 1 -> next cycle out_valid = 0 and in_ready = 1; neither the flushed words nor the same-cycle input ever appear.
- Out-of-range select: NUM_IN = 3, sel = 3, in_valid = 1 -> out_data = 0. With MUX_N_STAGE_SEL_CHECK_EN, sel_err = 1 from the next cycle and stays set across a flush.
- Async reset: assert rst_n = 0 mid-stream, away from a clock edge -> out_valid = 0, out_data = 0, in_ready = 1 immediately; the first word after release passes normally.
